// File: rtl/deser_if.sv
// deser_if: serial-in / parallel-out handshake bundle between a bit-stream source and the deserializer
interface deser_if #(parameter int DATA_W = 16);
    localparam int LEN_W = $clog2(DATA_W) + 1;
    logic              ser_data;
    logic              ser_data_val;
    logic [DATA_W-1:0] deser_data;
    logic [LEN_W-1:0]  deser_data_mod;
    logic              deser_data_val;
    logic              deser_err;
    logic              busy;
    modport master (
        output ser_data, ser_data_val,
        input  deser_data, deser_data_mod, deser_data_val, deser_err, busy
    );
    modport slave (
        input  ser_data, ser_data_val,
        output deser_data, deser_data_mod, deser_data_val, deser_err, busy
    );
endinterface

// File: rtl/deserializer.sv
// deserializer: rebuilds MSB-first serial runs into left-aligned words of 1..DATA_W bits
module deserializer #(
    parameter int DATA_W  = 16,
    parameter int MIN_LEN = 3
) (
    input  logic   clk_i,
    input  logic   rst_i,
    deser_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam int LEN_W = CNT_W + 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LEN_W-1:0]  mod_q, mod_d;
    logic              val_q, val_d;
    logic              err_q, err_d;
    logic              done;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] word;

    // next state: shift bits in, and on a terminating event publish the word or flag it as too short
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        mod_d   = mod_q;
        val_d   = 1'b0;
        err_d   = 1'b0;
        done    = 1'b0;
        len     = {1'b0, cnt_q};
        word    = shreg_q;
        case (state_q)
            IDLE: begin
                if (bus.ser_data_val) begin
                    shreg_d = {bus.ser_data, {(DATA_W-1){1'b0}}};
                    cnt_d   = CNT_W'(1);
                    state_d = SHIFT;
                end
            end
            default: begin
                if (bus.ser_data_val) begin
                    word[CNT_W'(DATA_W-1) - cnt_q] = bus.ser_data;
                    if (cnt_q == CNT_W'(DATA_W-1)) begin
                        done    = 1'b1;
                        len     = LEN_W'(DATA_W);
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        shreg_d = word;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end else begin
                    done    = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
        endcase
        if (done) begin
            if (len >= LEN_W'(MIN_LEN)) begin
                data_d = word & ~({DATA_W{1'b1}} >> len);
                mod_d  = (len == LEN_W'(DATA_W)) ? '0 : len;
                val_d  = 1'b1;
            end else begin
                err_d  = 1'b1;
            end
        end
    end

    // state and output registers; reset discards any partial word silently
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            mod_q   <= '0;
            val_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            mod_q   <= mod_d;
            val_q   <= val_d;
            err_q   <= err_d;
        end
    end

    assign bus.deser_data     = data_q;
    assign bus.deser_data_mod = mod_q;
    assign bus.deser_data_val = val_q;
    assign bus.deser_err      = err_q;
    assign bus.busy           = (cnt_q != '0);
endmodule

// File: tb/tb_deserializer.sv
// tb_deserializer: directed checks of word assembly, length encoding, short-word rejection and reset abort
module tb_deserializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    int   cyc = 0;
    int   p1 = -1;
    int   p2 = -1;

    deser_if #(.DATA_W(16)) bus();

    deserializer #(.DATA_W(16), .MIN_LEN(3)) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input logic v, input logic b);
        bus.ser_data_val = v;
        bus.ser_data     = b;
        @(posedge clk);
        #1;
        cyc++;
        chk("val_err_exclusive", {31'b0, bus.deser_data_val & bus.deser_err}, 32'd0);
    endtask

    task automatic send(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) step(1'b1, w[15-i]);
    endtask

    initial begin
        logic [15:0] w;
        bus.ser_data_val = 1'b0;
        bus.ser_data     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", {16'b0, bus.deser_data}, 32'd0);
        chk("reset_mod", {27'b0, bus.deser_data_mod}, 32'd0);
        chk("reset_val", {31'b0, bus.deser_data_val}, 32'd0);
        chk("reset_busy", {31'b0, bus.busy}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'bx);
            chk("idle_outputs", {bus.deser_data, 5'b0, bus.deser_data_mod, bus.deser_data_val, bus.deser_err, bus.busy}, 32'd0);
        end

        w = 16'hA5C3;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, w[15-i]);
            if (i < 15) chk("full_busy", {31'b0, bus.busy}, 32'd1);
        end
        chk("full_val", {31'b0, bus.deser_data_val}, 32'd1);
        chk("full_data", {16'b0, bus.deser_data}, 32'h0000A5C3);
        chk("full_mod", {27'b0, bus.deser_data_mod}, 32'd0);
        chk("full_busy_end", {31'b0, bus.busy}, 32'd0);
        step(1'b0, 1'b0);
        chk("full_val_pulse", {31'b0, bus.deser_data_val}, 32'd0);

        send(16'b1011_0100_0000_0000, 6);
        chk("short_no_early_val", {31'b0, bus.deser_data_val}, 32'd0);
        step(1'b0, 1'bx);
        chk("short_val", {31'b0, bus.deser_data_val}, 32'd1);
        chk("short_data", {16'b0, bus.deser_data}, 32'h0000B400);
        chk("short_mod", {27'b0, bus.deser_data_mod}, 32'd6);
        step(1'b0, 1'b1);
        chk("short_val_pulse", {31'b0, bus.deser_data_val}, 32'd0);
        chk("short_data_hold", {16'b0, bus.deser_data}, 32'h0000B400);

        send(16'hC000, 2);
        step(1'b0, 1'b0);
        chk("tooshort_err", {31'b0, bus.deser_err}, 32'd1);
        chk("tooshort_noval", {31'b0, bus.deser_data_val}, 32'd0);
        chk("tooshort_data", {16'b0, bus.deser_data}, 32'h0000B400);
        chk("tooshort_mod", {27'b0, bus.deser_data_mod}, 32'd6);
        step(1'b0, 1'b0);
        chk("tooshort_err_pulse", {31'b0, bus.deser_err}, 32'd0);

        w = 16'h1234;
        for (int i = 0; i < 32; i++) begin
            step(1'b1, (i < 16) ? w[15-i] : 1'b1);
            if (i == 15) begin
                chk("b2b_data1", {16'b0, bus.deser_data}, 32'h00001234);
                chk("b2b_mod1", {27'b0, bus.deser_data_mod}, 32'd0);
            end
            if (bus.deser_data_val) begin
                if (p1 < 0) p1 = cyc;
                else if (p2 < 0) p2 = cyc;
            end
        end
        chk("b2b_data2", {16'b0, bus.deser_data}, 32'h0000FFFF);
        chk("b2b_mod2", {27'b0, bus.deser_data_mod}, 32'd0);
        chk("b2b_both_pulses", {31'b0, p1 >= 0 && p2 >= 0}, 32'd1);
        chk("b2b_spacing", p2 - p1, 32'd16);
        step(1'b0, 1'b0);
        chk("b2b_no_extra", {30'b0, bus.deser_data_val, bus.deser_err}, 32'd0);

        send(16'hFFFF, 9);
        chk("abort_busy_before", {31'b0, bus.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, bus.busy}, 32'd0);
        chk("abort_data", {16'b0, bus.deser_data}, 32'd0);
        chk("abort_mod", {27'b0, bus.deser_data_mod}, 32'd0);
        step(1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        chk("abort_no_pulse", {30'b0, bus.deser_data_val, bus.deser_err}, 32'd0);
        send(16'h9000, 4);
        step(1'b0, 1'b0);
        chk("fresh_val", {31'b0, bus.deser_data_val}, 32'd1);
        chk("fresh_data", {16'b0, bus.deser_data}, 32'h00009000);
        chk("fresh_mod", {27'b0, bus.deser_data_mod}, 32'd4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
